onchip_dpram_avmm: RTL

//  Parametrised dual-port Avalon-MM on-chip RAM; successor to the single-port SoC onchip memory.
//  Two independent slaves (s1, s2) on one clock, each with read, write and byteenable.

---
 rtl/onchip_dpram_pkg.sv | 20 ++
 rtl/onchip_dpram_bank.sv | 54 +++++
 rtl/onchip_dpram_avmm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/onchip_dpram_pkg.sv
// Shared constants and helpers for the dual-port Avalon-MM on-chip RAM.
package onchip_dpram_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      LAT1 = 1'b0,
      LAT2 = 1'b1
   } lat_e;

   function automatic int unsigned nbytes(input int unsigned data_w);
      return data_w / BYTE_W;
   endfunction

   // Even parity: the stored bit makes the XOR of the data byte and the bit equal to zero
   function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/onchip_dpram_bank.sv
// True dual-port byte-lane RAM with registered, read-first outputs (mixed-port reads see old data).
// INIT_FILE names a preload image for the FPGA flow; "" leaves the array uninitialised.
module onchip_dpram_bank #(
   parameter int unsigned NLANES    = 4,
   parameter int unsigned LANE_W    = 8,
   parameter int unsigned DEPTH     = 5120,
   parameter int unsigned ADDR_W    = 13,
   parameter string       INIT_FILE = ""
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_W-1:0]             a_addr,
   input  logic                          a_we,
   input  logic [NLANES-1:0]             a_be,
   input  logic [NLANES-1:0][LANE_W-1:0] a_wdata,
   input  logic                          a_re,
   input  logic                          a_ok,
   output logic [NLANES-1:0][LANE_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0]             b_addr,
   input  logic                          b_we,
   input  logic [NLANES-1:0]             b_be,
   input  logic [NLANES-1:0][LANE_W-1:0] b_wdata,
   input  logic                          b_re,
   input  logic                          b_ok,
   output logic [NLANES-1:0][LANE_W-1:0] b_rdata
);

   typedef logic [NLANES-1:0][LANE_W-1:0] word_t;

   if (INIT_FILE != "") begin : g_store
      (* ram_init_file = INIT_FILE *) word_t mem [DEPTH];
   end else begin : g_store
      word_t mem [DEPTH];
   end

   // Lane enables never overlap at the same address, so write order is irrelevant
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NLANES); i++) begin
         if (b_we && b_be[i]) g_store.mem[b_addr][i] <= b_wdata[i];
         if (a_we && a_be[i]) g_store.mem[a_addr][i] <= a_wdata[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         if (a_re) a_rdata <= a_ok ? g_store.mem[a_addr] : '0;
         if (b_re) b_rdata <= b_ok ? g_store.mem[b_addr] : '0;
      end
   end

endmodule

// File: rtl/onchip_dpram_avmm.sv
// Dual-port Avalon-MM on-chip RAM: request qualify, collision masking, range check, read pipeline.
// Define ONCHIP_DPRAM_PARITY_EN to store per-byte even parity and flag mismatches on parity_err.
module onchip_dpram_avmm
   import onchip_dpram_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned DEPTH        = 5120,
   parameter int unsigned ADDR_W       = $clog2(DEPTH),
   parameter int unsigned READ_LATENCY = 1,
   parameter string       INIT_FILE    = "onchip_dpram_avmm.hex"
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                freeze,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic                s1_chipselect,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [DATA_W/8-1:0] s1_byteenable,
   input  logic [DATA_W-1:0]   s1_writedata,
   output logic [DATA_W-1:0]   s1_readdata,
   output logic                s1_readdatavalid,
   input  logic [ADDR_W-1:0]   s2_address,
   input  logic                s2_chipselect,
   input  logic                s2_read,
   input  logic                s2_write,
   input  logic [DATA_W/8-1:0] s2_byteenable,
   input  logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W-1:0]   s2_readdata,
   output logic                s2_readdatavalid,
   output logic                parity_err
);

   localparam int unsigned NB = nbytes(DATA_W);
`ifdef ONCHIP_DPRAM_PARITY_EN
   localparam int unsigned LANE_W = BYTE_W + 1;
`else
   localparam int unsigned LANE_W = BYTE_W;
`endif
   localparam lat_e LAT = (READ_LATENCY == 2) ? LAT2 : LAT1;

   typedef logic [NB-1:0][LANE_W-1:0] word_t;

   function automatic word_t to_lanes(input logic [DATA_W-1:0] d);
      word_t w;
      for (int i = 0; i < int'(NB); i++) begin
`ifdef ONCHIP_DPRAM_PARITY_EN
         w[i] = {byte_parity(d[i*BYTE_W +: BYTE_W]), d[i*BYTE_W +: BYTE_W]};
`else
         w[i] = d[i*BYTE_W +: BYTE_W];
`endif
      end
      return w;
   endfunction

   function automatic logic [DATA_W-1:0] to_data(input word_t w);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < int'(NB); i++) d[i*BYTE_W +: BYTE_W] = w[i][BYTE_W-1:0];
      return d;
   endfunction

   logic          s1_ok, s2_ok, s1_wr, s2_wr, s1_rd, s2_rd;
   logic [NB-1:0] s2_be;
   word_t         s1_rword, s2_rword, s1_oword, s2_oword;
   logic [1:0]    vld1, vld;

   // A write wins over a read on the same port; s1 owns bytes both ports write at one address
   always_comb begin
      s1_ok = 32'(s1_address) < DEPTH;
      s2_ok = 32'(s2_address) < DEPTH;
      s1_wr = s1_chipselect & s1_write & ~freeze & s1_ok;
      s2_wr = s2_chipselect & s2_write & ~freeze & s2_ok;
      s1_rd = s1_chipselect & s1_read & ~s1_write;
      s2_rd = s2_chipselect & s2_read & ~s2_write;
      s2_be = s2_byteenable;
      if (s1_wr && s2_wr && (s1_address == s2_address)) s2_be = s2_byteenable & ~s1_byteenable;
   end

   onchip_dpram_bank #(
      .NLANES    (NB),
      .LANE_W    (LANE_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .a_addr  (s1_address),
      .a_we    (s1_wr),
      .a_be    (s1_byteenable),
      .a_wdata (to_lanes(s1_writedata)),
      .a_re    (s1_rd),
      .a_ok    (s1_ok),
      .a_rdata (s1_rword),
      .b_addr  (s2_address),
      .b_we    (s2_wr),
      .b_be    (s2_be),
      .b_wdata (to_lanes(s2_writedata)),
      .b_re    (s2_rd),
      .b_ok    (s2_ok),
      .b_rdata (s2_rword)
   );

   always_ff @(posedge clk) begin
      if (reset) vld1 <= '0;
      else       vld1 <= {s2_rd, s1_rd};
   end

   if (LAT == LAT2) begin : g_lat2
      word_t s1_q, s2_q;

      // Output stage holds its last word between pulses
      always_ff @(posedge clk) begin
         if (reset) begin
            vld  <= '0;
            s1_q <= '0;
            s2_q <= '0;
         end else begin
            vld <= vld1;
            if (vld1[0]) s1_q <= s1_rword;
            if (vld1[1]) s2_q <= s2_rword;
         end
      end
      assign s1_oword = s1_q;
      assign s2_oword = s2_q;
   end else begin : g_lat1
      assign vld      = vld1;
      assign s1_oword = s1_rword;
      assign s2_oword = s2_rword;
   end

   assign s1_readdata      = to_data(s1_oword);
   assign s2_readdata      = to_data(s2_oword);
   assign s1_readdatavalid = vld[0];
   assign s2_readdatavalid = vld[1];

`ifdef ONCHIP_DPRAM_PARITY_EN
   function automatic logic lanes_bad(input word_t w);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(NB); i++) bad = bad | (^w[i]);
      return bad;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) parity_err <= 1'b0;
      else if ((vld[0] && lanes_bad(s1_oword)) || (vld[1] && lanes_bad(s2_oword)))
         parity_err <= 1'b1;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
